// File: rtl/video_timing_ctrl.sv
// Pong raster timing: pixel-enable divider, H/V pixel counters and blanking/sync sequencers.
// Every output is registered and updates on the same CLK_DRV edge as the count it describes.
module video_timing_ctrl #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_TOTAL      = 455,
  parameter int unsigned H_SYNC_START = 32,
  parameter int unsigned H_SYNC_END   = 64,
  parameter int unsigned H_BLANK_END  = 80,
  parameter int unsigned V_TOTAL      = 262,
  parameter int unsigned V_SYNC_START = 4,
  parameter int unsigned V_SYNC_END   = 8,
  parameter int unsigned V_BLANK_END  = 16
) (
  input  logic       CLK_DRV,
  input  logic       RESET_N,
  input  logic       RUN,
  output logic       PIX_CE,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC_N,
  output logic       VSYNC_N,
  output logic       LINE_START,
  output logic       FRAME_START
);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_chk_div
    $fatal(1, "video_timing_ctrl: CLK_DIV must be in 1..16");
  end
  if (!(0 < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_BLANK_END &&
        H_BLANK_END < H_TOTAL && H_TOTAL <= 512)) begin : g_chk_h
    $fatal(1, "video_timing_ctrl: illegal horizontal timing parameters");
  end
  if (!(0 < V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_BLANK_END &&
        V_BLANK_END < V_TOTAL && V_TOTAL <= 512)) begin : g_chk_v
    $fatal(1, "video_timing_ctrl: illegal vertical timing parameters");
  end

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_SS     = 9'(H_SYNC_START);
  localparam logic [8:0] H_SE     = 9'(H_SYNC_END);
  localparam logic [8:0] H_BE     = 9'(H_BLANK_END);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_SS     = 9'(V_SYNC_START);
  localparam logic [8:0] V_SE     = 9'(V_SYNC_END);
  localparam logic [8:0] V_BE     = 9'(V_BLANK_END);

  typedef enum logic [1:0] {StPre, StSync, StPost, StAct} seg_e;

  logic [3:0] div_q;
  seg_e       h_state_q, h_state_d;
  seg_e       v_state_q, v_state_d;
  logic [8:0] hcnt_d, vcnt_d;
  logic       h_wrap, v_wrap;

  // Segment transitions are keyed on the count the segment will describe after this step.
  function automatic seg_e seg_next(input seg_e cur, input logic [8:0] nxt,
                                    input logic [8:0] s_start, input logic [8:0] s_end,
                                    input logic [8:0] b_end);
    seg_e res;
    res = cur;
    case (cur)
      StPre:   if (nxt == s_start) res = StSync;
      StSync:  if (nxt == s_end) res = (s_end == b_end) ? StAct : StPost;
      StPost:  if (nxt == b_end) res = StAct;
      StAct:   if (nxt == 9'd0) res = StPre;
      default: res = StPre;
    endcase
    return res;
  endfunction

  always_comb begin
    h_wrap    = (HCNT == H_LAST);
    v_wrap    = (VCNT == V_LAST);
    hcnt_d    = h_wrap ? 9'd0 : 9'(HCNT + 9'd1);
    vcnt_d    = v_wrap ? 9'd0 : 9'(VCNT + 9'd1);
    h_state_d = seg_next(h_state_q, hcnt_d, H_SS, H_SE, H_BE);
    v_state_d = seg_next(v_state_q, vcnt_d, V_SS, V_SE, V_BE);
  end

  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q       <= 4'd0;
      HCNT        <= 9'd0;
      VCNT        <= 9'd0;
      h_state_q   <= StPre;
      v_state_q   <= StPre;
      PIX_CE      <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      HBLANK      <= 1'b1;
      VBLANK      <= 1'b1;
      HSYNC_N     <= 1'b1;
      VSYNC_N     <= 1'b1;
    end else if (!RUN) begin
      // Frozen: levels and div hold, strobes drop so no pixel is issued twice.
      PIX_CE      <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q       <= 4'd0;
      PIX_CE      <= 1'b1;
      HCNT        <= hcnt_d;
      h_state_q   <= h_state_d;
      HBLANK      <= (h_state_d != StAct);
      HSYNC_N     <= (h_state_d != StSync);
      LINE_START  <= h_wrap;
      FRAME_START <= h_wrap && v_wrap;
      if (h_wrap) begin
        VCNT      <= vcnt_d;
        v_state_q <= v_state_d;
        VBLANK    <= (v_state_d != StAct);
        VSYNC_N   <= (v_state_d != StSync);
      end
    end else begin
      div_q       <= 4'(div_q + 4'd1);
      PIX_CE      <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end
  end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Synchronous video timing sequencer for the Pong raster. It divides `CLK_DRV` into a one-cycle pixel enable and sequences the horizontal and vertical pixel counters through a line/frame state machine. It produces the blanking and sync strobes and the line/frame start pulses consumed by the game-logic, score and sound blocks. It replaces the ripple-counter chain with a single-clock design that downstream logic can enable-gate.

## Interface
Parameters:
- `CLK_DIV`, 4: `CLK_DRV` cycles per pixel; range 1..16.
- `H_TOTAL`, 455: pixels per line.
- `H_SYNC_START`, 32: first HSYNC pixel.
- `H_SYNC_END`, 64: first pixel after HSYNC.
- `H_BLANK_END`, 80: first active pixel.
- `V_TOTAL`, 262: lines per frame.
- `V_SYNC_START`, 4: first VSYNC line.
- `V_SYNC_END`, 8: first line after VSYNC.
- `V_BLANK_END`, 16: first active line.

Ports:
- `CLK_DRV` in 1: sole clock.
- `RESET_N` in 1: asynchronous, active-low reset.
- `RUN` in 1: advance enable; low freezes all state.
- `PIX_CE` out 1: one-`CLK_DRV` pulse per pixel.
- `HCNT` out 9: horizontal pixel count.
- `VCNT` out 9: vertical line count.
- `HBLANK`, `VBLANK` out 1: active-high blanking.
- `HSYNC_N`, `VSYNC_N` out 1: active-low sync.
- `LINE_START` out 1: pulse when `HCNT` wraps to 0.
- `FRAME_START` out 1: pulse when both counters wrap to 0.

## Operation
- Elaboration check: `0 < H_SYNC_START < H_SYNC_END <= H_BLANK_END < H_TOTAL <= 512`. Same ordering for the V parameters, with `V_TOTAL <= 512`. A violation is a fatal elaboration error.
- Divider `div` runs 0..CLK_DIV-1, advancing only while `RUN`=1.
  - On the edge where `div`=CLK_DIV-1: `div`<=0, `PIX_CE`<=1, and `HCNT` advances.
  - On every other edge: `PIX_CE`<=0.
  - `CLK_DIV`=1: `PIX_CE` stays high continuously while `RUN`=1.
- `HCNT` advance rule: `HCNT`<=`HCNT`+1. At `H_TOTAL`-1 it instead wraps to 0, `VCNT` advances, and `LINE_START`<=1.
- `VCNT` advance rule: at `V_TOTAL`-1 it wraps to 0 and `FRAME_START`<=1. `FRAME_START` is only ever set together with `LINE_START`.
- H state machine, advancing on each pixel step (targets are decided from the next `HCNT`):
  - H_PRE (0..H_SYNC_START-1) -> H_SYNC at H_SYNC_START.
  - H_SYNC -> H_POST at H_SYNC_END.
  - H_POST -> H_ACT at H_BLANK_END. When H_SYNC_END = H_BLANK_END, H_SYNC goes directly to H_ACT.
  - H_ACT -> H_PRE on wrap.
- V state machine: same four states on `VCNT`, advancing only on a line wrap.
- Output decode:
  - `HBLANK`=1 in every H state except H_ACT; `HSYNC_N`=0 only in H_SYNC.
  - `VBLANK` and `VSYNC_N` decode the V states the same way.
  - All outputs are registered and change on the same edge as the counter value they describe.
- `RUN`=0: `div`, counters, states and level outputs hold. `PIX_CE`, `LINE_START` and `FRAME_START` are forced to 0. When `RUN` returns to 1, counting continues from the held `div` with no pixel lost or repeated.

## Timing
- Reset values (asynchronous, while `RESET_N`=0):
  - `div`=0, `HCNT`=0, `VCNT`=0, states H_PRE/V_PRE.
  - `PIX_CE`=0, `LINE_START`=0, `FRAME_START`=0.
  - `HBLANK`=1, `VBLANK`=1, `HSYNC_N`=1, `VSYNC_N`=1.
- Reset asserted mid-line forces these values immediately. The first `PIX_CE` occurs CLK_DIV edges after `RESET_N` deasserts with `RUN`=1, and `HCNT` becomes 1 on that edge.
- Pulse outputs are exactly one `CLK_DRV` cycle wide, never back-to-back unless `CLK_DIV`=1.
- Line period: H_TOTAL×CLK_DIV `CLK_DRV` cycles. Frame period: V_TOTAL×H_TOTAL×CLK_DIV cycles.
- Latency: `PIX_CE`, the new `HCNT` and the decoded flags all appear together, registered on the same edge.

## Test plan
- Reset then `RUN`=1, defaults: `PIX_CE` pulses every 4 cycles. `HCNT` steps 0,1,2…454,0. `LINE_START` is high exactly when `HCNT` becomes 0, and `VCNT` becomes 1 at that pixel.
- One line at defaults: `HSYNC_N`=0 for `HCNT` 32..63 (32 pixels, 128 cycles). `HBLANK`=0 for `HCNT` 80..454. The line is exactly 1820 cycles.
- Full frame: `VSYNC_N`=0 for `VCNT` 4..7 and `VBLANK`=0 for `VCNT` 16..261. `FRAME_START` fires once per 476,840 cycles, coincident with `LINE_START`.
- `RUN` dropped for 10 cycles with `div`=2 at `HCNT`=100: all outputs hold and no pulses occur. After `RUN` returns, `HCNT`=101 appears exactly 2 cycles later.
- `RESET_N` pulsed low at `HCNT`=300, `VCNT`=20: all outputs take their reset values asynchronously, before the next edge. The first pixel after release yields `HCNT`=1, `VCNT`=0.
- `CLK_DIV`=1, `H_TOTAL`=8, `H_SYNC_START`=1, `H_SYNC_END`=3, `H_BLANK_END`=3: `PIX_CE` is constantly high and H_SYNC goes directly to H_ACT. `LINE_START` fires every 8 cycles.
